// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath definitions: widths, the zero-register index and the
// memory-stage state encoding.
package legv8_pkg;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;

    // X31 reads as zero in the register file; the memory stage passes it
    // through untouched and leaves the filtering to the register file.
    localparam logic [REG_W-1:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/data_ram.sv
// Single-port data memory: synchronous write, word-indexed read.
// The read value only ever reaches the outside world through the registered
// write-back bundle of the memory stage.
module data_ram #(
    parameter int DEPTH_WORDS = 128,
    parameter int DATA_W      = 64
) (
    input  logic                           Clock,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Commit a store on the clock edge; contents are never reset.
    always_ff @(posedge Clock) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_stage.sv
// LEGv8 memory-access stage. Legal loads/stores hold Stall high for LATENCY
// cycles, complete on the edge into DONE, and present a registered
// write-back bundle for one cycle. Illegal requests produce a one-cycle
// AccessErr pulse and never touch memory.
module data_mem_stage #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2,
    parameter int DATA_W      = 64
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [4:0]        WriteReg,
    output logic              Stall,
    output logic [DATA_W-1:0] WBData,
    output logic [4:0]        WBReg,
    output logic              WBEn,
    output logic              AccessErr
);

    import legv8_pkg::*;

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // A single-cycle build never uses the counter, but keep it one bit wide.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    mem_state_e        state;
    logic [CNT_W-1:0]  count;

    logic              mem_op;
    logic              illegal;
    logic              legal_req;
    logic              complete;
    logic              ram_we;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] wb_sel;
    logic              unused_addr_hi;

    // Upper address bits do not select a word; the address space wraps.
    assign idx            = Address[IDX_W+2:3];
    assign unused_addr_hi = ^Address[DATA_W-1:IDX_W+3];

    assign mem_op    = MemRead | MemWrite;
    assign illegal   = mem_op & ((Address[2:0] != 3'b000) | (MemRead & MemWrite));
    assign legal_req = mem_op & ~illegal;

    // The completion edge is the one that moves the FSM into DONE.
    assign complete = ((state == IDLE) && legal_req && (LATENCY == 1)) ||
                      ((state == BUSY) && (count == '0));

    assign Stall = ((state == IDLE) && legal_req) || (state == BUSY);

    // Reset on the completion edge wins: the store is dropped.
    assign ram_we = complete & MemWrite & ~Reset;

    assign wb_sel = (MemRead & MemtoReg) ? rdata : Address;

    data_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W)
    ) u_ram (
        .Clock (Clock),
        .we    (ram_we),
        .idx   (idx),
        .wdata (WriteData),
        .rdata (rdata)
    );

    // Access sequencing: IDLE -> (BUSY countdown) -> DONE -> IDLE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (legal_req) begin
                        if (LATENCY == 1) begin
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                            count <= CNT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (count == '0) begin
                        state <= DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write-back bundle and error pulse toward the register file.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            WBData    <= '0;
            WBReg     <= '0;
            WBEn      <= 1'b0;
            AccessErr <= 1'b0;
        end else begin
            AccessErr <= 1'b0;
            if (complete) begin
                WBData <= wb_sel;
                WBReg  <= WriteReg;
                WBEn   <= RegWrite & ~MemWrite;
            end else begin
                case (state)
                    IDLE: begin
                        if (illegal) begin
                            AccessErr <= 1'b1;
                            WBEn      <= 1'b0;
                        end else if (legal_req) begin
                            WBEn <= 1'b0;
                        end else begin
                            WBData <= Address;
                            WBReg  <= WriteReg;
                            WBEn   <= RegWrite;
                        end
                    end
                    DONE: begin
                        WBEn <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_mem_stage.sv
// Randomized bench for data_mem_stage against a transaction-level model:
// memory is a plain array, each instruction's expected stall length and
// write-back bundle are derived from the access rules.
module tb_data_mem_stage;

    import legv8_pkg::*;

    localparam int LAT = 2;

    logic        Clock;
    logic        Reset;
    logic        MemRead, MemWrite, MemtoReg, RegWrite;
    logic [63:0] Address, WriteData;
    logic [4:0]  WriteReg;
    logic        Stall, WBEn, AccessErr;
    logic [63:0] WBData;
    logic [4:0]  WBReg;

    logic        l1_MemRead, l1_MemWrite, l1_MemtoReg, l1_RegWrite;
    logic [63:0] l1_Address, l1_WriteData;
    logic [4:0]  l1_WriteReg;
    logic        l1_Stall, l1_WBEn, l1_AccessErr;
    logic [63:0] l1_WBData;
    logic [4:0]  l1_WBReg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] ref_mem [128];
    logic [63:0] exp_wbdata;
    logic [4:0]  exp_wbreg;

    data_mem_stage #(.DEPTH_WORDS(128), .LATENCY(LAT), .DATA_W(64)) dut (
        .Clock(Clock), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Address(Address),
        .WriteData(WriteData), .WriteReg(WriteReg), .Stall(Stall),
        .WBData(WBData), .WBReg(WBReg), .WBEn(WBEn), .AccessErr(AccessErr)
    );

    data_mem_stage #(.DEPTH_WORDS(128), .LATENCY(1), .DATA_W(64)) dut_l1 (
        .Clock(Clock), .Reset(Reset), .MemRead(l1_MemRead), .MemWrite(l1_MemWrite),
        .MemtoReg(l1_MemtoReg), .RegWrite(l1_RegWrite), .Address(l1_Address),
        .WriteData(l1_WriteData), .WriteReg(l1_WriteReg), .Stall(l1_Stall),
        .WBData(l1_WBData), .WBReg(l1_WBReg), .WBEn(l1_WBEn), .AccessErr(l1_AccessErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit rd, input bit wr, input bit m2r, input bit rw,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [4:0] wreg);
        MemRead   = rd;
        MemWrite  = wr;
        MemtoReg  = m2r;
        RegWrite  = rw;
        Address   = addr;
        WriteData = wdata;
        WriteReg  = wreg;
    endtask

    // Runs one instruction; entered and left just after a rising edge.
    task automatic do_instr(input string tag, input bit rd, input bit wr, input bit m2r,
                            input bit rw, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [4:0] wreg);
        bit         memop, illegal;
        int         stalls;
        logic [6:0] widx;
        memop   = rd | wr;
        illegal = memop && ((addr[2:0] != 3'b000) || (rd && wr));
        widx    = addr[9:3];
        drive(rd, wr, m2r, rw, addr, wdata, wreg);
        if (!memop || illegal) begin
            @(negedge Clock);
            check({tag, ".stall"}, Stall, 1'b0);
            @(posedge Clock); #1;
            if (illegal) begin
                check({tag, ".err"}, AccessErr, 1'b1);
                check({tag, ".wben"}, WBEn, 1'b0);
                check({tag, ".wbdata_hold"}, WBData, exp_wbdata);
            end else begin
                exp_wbdata = addr;
                exp_wbreg  = wreg;
                check({tag, ".err"}, AccessErr, 1'b0);
                check({tag, ".wben"}, WBEn, rw);
                check({tag, ".wbreg"}, WBReg, exp_wbreg);
                check({tag, ".wbdata"}, WBData, exp_wbdata);
            end
        end else begin
            stalls = 0;
            @(negedge Clock);
            while (Stall === 1'b1 && stalls < 8) begin
                stalls++;
                @(negedge Clock);
            end
            exp_wbdata = (rd && m2r) ? ref_mem[widx] : addr;
            exp_wbreg  = wreg;
            if (wr) ref_mem[widx] = wdata;
            check({tag, ".stall_cycles"}, 64'(stalls), 64'(LAT));
            check({tag, ".wben"}, WBEn, rw & ~wr);
            check({tag, ".wbreg"}, WBReg, exp_wbreg);
            check({tag, ".wbdata"}, WBData, exp_wbdata);
            check({tag, ".err"}, AccessErr, 1'b0);
            @(posedge Clock); #1;
            check({tag, ".wben_drop"}, WBEn, 1'b0);
            check({tag, ".wbdata_hold"}, WBData, exp_wbdata);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r, stalls;
        bit          rd, wr, m2r, rw;
        logic [63:0] addr, wdata, old20, l1_val;
        logic [4:0]  wreg;

        Reset = 1'b1;
        drive(0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
        l1_MemRead = 0; l1_MemWrite = 0; l1_MemtoReg = 0; l1_RegWrite = 0;
        l1_Address = '0; l1_WriteData = '0; l1_WriteReg = '0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        check("reset.stall", Stall, 1'b0);
        check("reset.wbdata", WBData, 64'h0);
        check("reset.wbreg", WBReg, 5'd0);
        check("reset.wben", WBEn, 1'b0);
        check("reset.err", AccessErr, 1'b0);
        exp_wbdata = '0;
        exp_wbreg  = '0;
        @(posedge Clock); #1;

        // Give every word a known value.
        for (int i = 0; i < 128; i++) begin
            do_instr("fill", 0, 1, 0, 1'($urandom), 64'(i * 8), {$urandom, $urandom}, 5'($urandom));
        end

        do_instr("alu", 0, 0, 0, 1, 64'h2A, 64'h0, 5'd5);
        do_instr("stur", 0, 1, 0, 0, 64'h10, 64'hDEADBEEF, 5'd0);
        do_instr("ldur", 1, 0, 1, 1, 64'h10, 64'h0, 5'd9);
        do_instr("misaligned", 1, 0, 1, 1, 64'h13, 64'h0, 5'd4);
        do_instr("ldur_after_mis", 1, 0, 1, 1, 64'h10, 64'h0, 5'd4);
        do_instr("rd_wr_both", 1, 1, 1, 1, 64'h18, 64'h1111_2222_3333_4444, 5'd6);
        do_instr("ldur_after_both", 1, 0, 1, 1, 64'h18, 64'h0, 5'd6);
        do_instr("wrap_st", 0, 1, 0, 0, 64'h400, 64'h55, 5'd0);
        do_instr("wrap_ld", 1, 0, 1, 1, 64'h0, 64'h0, 5'd7);
        do_instr("xzr_alu", 0, 0, 0, 1, 64'h77, 64'h0, XZR);
        do_instr("xzr_ld", 1, 0, 1, 1, 64'h28, 64'h0, XZR);
        do_instr("ld_addr_sel", 1, 0, 0, 1, 64'h30, 64'h0, 5'd12);

        // Reset while the store sits in its final BUSY cycle.
        old20 = ref_mem[4];
        drive(0, 1, 0, 0, 64'h20, 64'hCAFE_F00D_0BAD_BEEF, 5'd0);
        @(negedge Clock);
        check("rst_mid.stall_idle", Stall, 1'b1);
        @(posedge Clock); #1;
        Reset = 1'b1;
        @(negedge Clock);
        check("rst_mid.stall_busy", Stall, 1'b1);
        @(posedge Clock); #1;
        Reset = 1'b0;
        drive(0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
        @(negedge Clock);
        check("rst_mid.stall", Stall, 1'b0);
        check("rst_mid.wbdata", WBData, 64'h0);
        check("rst_mid.wbreg", WBReg, 5'd0);
        check("rst_mid.wben", WBEn, 1'b0);
        check("rst_mid.err", AccessErr, 1'b0);
        exp_wbdata = '0;
        exp_wbreg  = '0;
        @(posedge Clock); #1;
        do_instr("rst_mid.reload", 1, 0, 1, 1, 64'h20, 64'h0, 5'd2);
        check("rst_mid.old_kept", ref_mem[4], old20);

        // Randomized instruction mix.
        for (int n = 0; n < 300; n++) begin
            r     = $urandom_range(0, 9);
            addr  = {$urandom, $urandom};
            wdata = {$urandom, $urandom};
            wreg  = 5'($urandom);
            rw    = 1'($urandom);
            m2r   = ($urandom_range(0, 3) != 0);
            rd    = 0;
            wr    = 0;
            if (r >= 3 && r <= 5) begin
                rd = 1; addr[2:0] = 3'b000;
            end else if (r == 6 || r == 7) begin
                wr = 1; addr[2:0] = 3'b000;
            end else if (r == 8) begin
                if ($urandom_range(0, 1) != 0) rd = 1; else wr = 1;
                addr[2:0] = 3'($urandom_range(1, 7));
            end else if (r == 9) begin
                rd = 1; wr = 1;
            end
            do_instr("rand", rd, wr, m2r, rw, addr, wdata, wreg);
        end

        // Single-cycle-latency build: store, then load back.
        l1_val = 64'h0123_4567_89AB_CDEF;
        l1_MemWrite = 1; l1_RegWrite = 1; l1_Address = 64'h8; l1_WriteData = l1_val;
        stalls = 0;
        @(negedge Clock);
        while (l1_Stall === 1'b1 && stalls < 8) begin
            stalls++;
            @(negedge Clock);
        end
        check("lat1.st_stalls", 64'(stalls), 64'd1);
        check("lat1.st_wben", l1_WBEn, 1'b0);
        @(posedge Clock); #1;
        l1_MemWrite = 0; l1_MemRead = 1; l1_MemtoReg = 1; l1_RegWrite = 1; l1_WriteReg = 5'd3;
        stalls = 0;
        @(negedge Clock);
        while (l1_Stall === 1'b1 && stalls < 8) begin
            stalls++;
            @(negedge Clock);
        end
        check("lat1.ld_stalls", 64'(stalls), 64'd1);
        check("lat1.ld_wben", l1_WBEn, 1'b1);
        check("lat1.ld_wbdata", l1_WBData, l1_val);
        check("lat1.ld_wbreg", l1_WBReg, 5'd3);
        @(posedge Clock); #1;
        l1_MemRead = 0; l1_MemtoReg = 0; l1_RegWrite = 0;
        check("lat1.wben_drop", l1_WBEn, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
